// File: rtl/lsmitll_jtl_pulse_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsmitll_jtl_pkg
// Purpose : Shared types and width helpers for the JTL pulse scheduler.
//           The FSM state enum, default sizing and the width functions used
//           by the interface, the arbiter and the top level.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package lsmitll_jtl_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_GAP     = 2'd2,
    ST_HALT    = 2'd3
  } sched_state_t;

  // Index width; a single requester still needs one bit so ports never collapse.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the value m itself.
  function automatic int cnt_width(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  localparam int N_REQ_DEF        = 4;
  localparam int MAX_INFLIGHT_DEF = 4;
  localparam int ID_W             = id_width(N_REQ_DEF);
  localparam int CNT_W            = cnt_width(MAX_INFLIGHT_DEF);

endpackage : lsmitll_jtl_pkg
`default_nettype wire

// File: rtl/lsmitll_jtl_pulse_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : lsmitll_jtl_pulse_sched_if
// Purpose : Request/grant and line signals of the JTL pulse scheduler.
// Ports   : req, line_q                  -> driven by the harness (master)
//           ack, grant_id, line_a,
//           rx_pulse, inflight, ready,
//           err_timeout, err_spurious    -> driven by the scheduler (slave)
// Rev     : 1.0  initial release
// ============================================================================
interface lsmitll_jtl_pulse_sched_if
  import lsmitll_jtl_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_INFLIGHT = 4
);

  localparam int c_id_w  = id_width(N_REQ);
  localparam int c_cnt_w = cnt_width(MAX_INFLIGHT);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   ack;
  logic [c_id_w-1:0]  grant_id;
  logic               line_a;
  logic               line_q;
  logic               rx_pulse;
  logic [c_cnt_w-1:0] inflight;
  logic               ready;
  logic               err_timeout;
  logic               err_spurious;

  modport master (
    output req, line_q,
    input  ack, grant_id, line_a, rx_pulse, inflight, ready,
           err_timeout, err_spurious
  );

  modport slave (
    input  req, line_q,
    output ack, grant_id, line_a, rx_pulse, inflight, ready,
           err_timeout, err_spurious
  );

endinterface : lsmitll_jtl_pulse_sched_if
`default_nettype wire

// File: rtl/lsmitll_jtl_pulse_sched_arb.sv
`default_nettype none
// ============================================================================
// Module  : lsmitll_rr_arb
// Purpose : Combinational round-robin pick. Searches req from the pointer
//           upward with wrap and returns the first requester found.
// Ports   : i_req    [N_REQ]  request levels
//           i_ptr    [ID_W]   search start index (0..N_REQ-1)
//           o_grant  [N_REQ]  one-hot winner (all zero if none)
//           o_idx    [ID_W]   winner index (0 if none)
//           o_valid           at least one request present
// Rev     : 1.0  initial release
// ============================================================================
module lsmitll_rr_arb
  import lsmitll_jtl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  wire  [N_REQ-1:0] i_req,
  input  wire  [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_valid
);

  always_comb begin
    int k;
    k       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // Wrap without a modulo: pointer is always < N_REQ, so one subtract suffices.
      k = int'(i_ptr) + i;
      if (k >= N_REQ) begin
        k = k - N_REQ;
      end
      if (!o_valid && i_req[k]) begin
        o_valid    = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = ID_W'(k);
      end
    end
  end

endmodule : lsmitll_rr_arb
`default_nettype wire

// File: rtl/lsmitll_jtl_pulse_sched.sv
`default_nettype none
// ============================================================================
// Module  : lsmitll_jtl_pulse_sched
// Purpose : Shares one toggle-encoded JTL line among N_REQ requesters.
//           Each grant toggles line_a, consecutive toggles are spaced by at
//           least MIN_GAP cycles, pulses in flight are counted and each
//           toggle seen on line_q is reported as an arrival.
// Ports   : clk, rst_n (async, active-low)
//           bus (slave modport): req/line_q in; ack, grant_id, line_a,
//           rx_pulse, inflight, ready, err_timeout, err_spurious out
// Rev     : 1.0  initial release
// ============================================================================
module lsmitll_jtl_pulse_sched
  import lsmitll_jtl_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MIN_GAP      = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int TIMEOUT      = 64,
  parameter int BEGIN_CYCLES = 8
) (
  input wire                         clk,
  input wire                         rst_n,
  lsmitll_jtl_pulse_sched_if.slave   bus
);

  localparam int c_id_w    = id_width(N_REQ);
  localparam int c_cnt_w   = cnt_width(MAX_INFLIGHT);
  localparam int c_gap_w   = cnt_width(MIN_GAP);
  localparam int c_age_w   = cnt_width(TIMEOUT);
  localparam int c_start_w = cnt_width(BEGIN_CYCLES);

  localparam logic [c_id_w-1:0]    c_last_id      = c_id_w'(N_REQ - 1);
  localparam logic [c_cnt_w-1:0]   c_max_inflight = c_cnt_w'(MAX_INFLIGHT);
  localparam logic [c_cnt_w-1:0]   c_cnt_one      = c_cnt_w'(1);
  localparam logic [c_gap_w-1:0]   c_gap_reload   = c_gap_w'(MIN_GAP - 1);
  localparam logic [c_gap_w-1:0]   c_gap_one      = c_gap_w'(1);
  localparam logic [c_age_w-1:0]   c_age_limit    = c_age_w'(TIMEOUT - 1);
  localparam logic [c_age_w-1:0]   c_age_one      = c_age_w'(1);
  localparam logic [c_start_w-1:0] c_start_last   = c_start_w'(BEGIN_CYCLES - 1);
  localparam logic [c_start_w-1:0] c_start_one    = c_start_w'(1);

  sched_state_t         r_state;
  logic [c_start_w-1:0] r_start_cnt;
  logic [c_gap_w-1:0]   r_gap_cnt;
  logic [c_age_w-1:0]   r_age;
  logic [c_id_w-1:0]    r_ptr;
  logic [c_id_w-1:0]    r_grant_id;
  logic [N_REQ-1:0]     r_ack;
  logic [c_cnt_w-1:0]   r_inflight;
  logic                 r_line_a;
  logic                 r_line_q_d;
  logic                 r_rx_pulse;
  logic                 r_ready;
  logic                 r_err_timeout;
  logic                 r_err_spurious;

  logic [N_REQ-1:0]     w_grant_oh;
  logic [c_id_w-1:0]    w_grant_idx;
  logic                 w_grant_vld;
  logic [c_id_w-1:0]    w_ptr_next;
  logic                 w_rx;
  logic                 w_spur_set;
  logic                 w_tmo_set;
  logic                 w_err_set;
  logic                 w_issue;

  lsmitll_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (c_id_w)
  ) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_valid (w_grant_vld)
  );

  // Any level change on line_q is one arriving pulse.
  assign w_rx       = bus.line_q ^ r_line_q_d;
  assign w_spur_set = w_rx && (r_inflight == '0);
  assign w_tmo_set  = (r_age == c_age_limit);
  assign w_err_set  = w_spur_set || w_tmo_set;

  // An edge that raises an error issues nothing; the FSM goes straight to HALT.
  assign w_issue    = (r_state == ST_IDLE) && w_grant_vld &&
                      (r_inflight < c_max_inflight) && !w_err_set;

  assign w_ptr_next = (w_grant_idx == c_last_id) ? '0 : (w_grant_idx + c_id_w'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_STARTUP;
      r_start_cnt    <= '0;
      r_gap_cnt      <= '0;
      r_age          <= '0;
      r_ptr          <= '0;
      r_grant_id     <= '0;
      r_ack          <= '0;
      r_inflight     <= '0;
      r_line_a       <= 1'b0;
      r_line_q_d     <= 1'b0;
      r_rx_pulse     <= 1'b0;
      r_ready        <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_line_q_d <= bus.line_q;
      r_rx_pulse <= w_rx;
      r_ack      <= w_issue ? w_grant_oh : '0;

      if (w_issue) begin
        r_line_a   <= ~r_line_a;
        r_grant_id <= w_grant_idx;
        r_ptr      <= w_ptr_next;
      end

      // Issue and arrival on the same edge cancel; arrival never wraps below 0.
      if (w_issue && !w_rx) begin
        r_inflight <= r_inflight + c_cnt_one;
      end else if (!w_issue && w_rx && (r_inflight != '0)) begin
        r_inflight <= r_inflight - c_cnt_one;
      end

      // Age tracks how long the line has been silent while pulses are owed.
      if (w_rx || (r_inflight == '0)) begin
        r_age <= '0;
      end else if (r_age != c_age_limit) begin
        r_age <= r_age + c_age_one;
      end

      if (w_spur_set) begin
        r_err_spurious <= 1'b1;
      end
      if (w_tmo_set) begin
        r_err_timeout <= 1'b1;
      end

      if (w_err_set) begin
        r_state <= ST_HALT;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          ST_STARTUP: begin
            if (r_start_cnt == c_start_last) begin
              r_state <= ST_IDLE;
              r_ready <= 1'b1;
            end else begin
              r_start_cnt <= r_start_cnt + c_start_one;
            end
          end
          ST_IDLE: begin
            if (w_issue) begin
              r_gap_cnt <= c_gap_reload;
              if (MIN_GAP > 1) begin
                r_state <= ST_GAP;
              end
            end
          end
          ST_GAP: begin
            // Leaving on the count of 1 makes the toggle spacing exactly MIN_GAP.
            if ((r_gap_cnt == c_gap_one) || (r_gap_cnt == '0)) begin
              r_state <= ST_IDLE;
            end
            if (r_gap_cnt != '0) begin
              r_gap_cnt <= r_gap_cnt - c_gap_one;
            end
          end
          ST_HALT: begin
            r_state <= ST_HALT;
          end
          default: begin
            r_state <= ST_HALT;
          end
        endcase
      end
    end
  end

  assign bus.ack          = r_ack;
  assign bus.grant_id     = r_grant_id;
  assign bus.line_a       = r_line_a;
  assign bus.rx_pulse     = r_rx_pulse;
  assign bus.inflight     = r_inflight;
  assign bus.ready        = r_ready;
  assign bus.err_timeout  = r_err_timeout;
  assign bus.err_spurious = r_err_spurious;

endmodule : lsmitll_jtl_pulse_sched
`default_nettype wire
